// File: rtl/ro_pkg.sv
// Shared constants and FSM state encoding for the readout frame capture block.
package ro_pkg;

   localparam int SLOTS   = 8;
   localparam int SEQ_W   = 8;
   localparam int GAP_MAX = 4;
   localparam int FRAME_W = 2 * SLOTS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/ro_fall_det.sv
// Registers the divide-by-8 frame clock as data and flags its falling edge.
module ro_fall_det
   import ro_pkg::*;
(
   input  logic clk_ext,
   input  logic rst,
   input  logic clk_8,
   output logic fall
);

   logic c8_q;

   // c8_q resets high so a low clk_8 right after reset counts as a fall
   always_ff @(posedge clk_ext) begin
      if (rst) begin
         c8_q <= 1'b1;
      end else begin
         c8_q <= clk_8;
      end
   end

   assign fall = c8_q & ~clk_8;

endmodule

// File: rtl/ro_frame_capture.sv
// Samples the shared 2-bit readout bus once per slot, assembles frames and
// presents them over valid/ready with sticky overflow and sync error pulse.
module ro_frame_capture
   import ro_pkg::*;
#(
   parameter int SLOTS_P   = ro_pkg::SLOTS,
   parameter int SEQ_W_P   = ro_pkg::SEQ_W,
   parameter int GAP_MAX_P = ro_pkg::GAP_MAX
)
(
   input  logic                 clk_ext,
   input  logic                 rst,
   input  logic                 clk_8,
   input  logic [1:0]           bus_in,
   input  logic                 cap_en,
   input  logic                 frame_ready,
   input  logic                 ovf_clr,
   output logic                 frame_valid,
   output logic [2*SLOTS_P-1:0] frame_data,
   output logic [SEQ_W_P-1:0]   frame_seq,
   output logic                 overflow,
   output logic                 sync_err
);

   localparam int FW    = 2 * SLOTS_P;
   localparam int CNT_W = (SLOTS_P > 1) ? $clog2(SLOTS_P) : 1;
   localparam int GAP_W = $clog2(GAP_MAX_P + 1) + 1;

   state_t            state, state_n;
   logic [CNT_W-1:0]  slot_cnt, slot_n;
   logic [GAP_W-1:0]  gap_cnt, gap_n;
   logic [SEQ_W_P-1:0] seq;
   logic [FW-1:0]     asm_q;
   logic [FW-1:0]     shift_n;
   logic              fall;
   logic              sample;
   logic              complete;
   logic              err;

   ro_fall_det u_fall_det (
      .clk_ext (clk_ext),
      .rst     (rst),
      .clk_8   (clk_8),
      .fall    (fall)
   );

   // New slot enters at the top, so after SLOTS samples slot k sits at [2k+1:2k]
   assign shift_n = {bus_in, asm_q[FW-1:2]};

   always_comb begin
      state_n  = state;
      slot_n   = slot_cnt;
      gap_n    = gap_cnt;
      sample   = 1'b0;
      complete = 1'b0;
      err      = 1'b0;
      if (!cap_en) begin
         state_n = IDLE;
         slot_n  = '0;
         gap_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (fall) begin
                  sample  = 1'b1;
                  slot_n  = CNT_W'(1);
                  state_n = CAPT;
               end
            end
            CAPT: begin
               sample = 1'b1;
               if (fall) begin
                  // short frame: drop what we have and treat this as slot 0
                  err    = 1'b1;
                  slot_n = CNT_W'(1);
               end else if (slot_cnt == CNT_W'(SLOTS_P - 1)) begin
                  complete = 1'b1;
                  slot_n   = '0;
                  gap_n    = '0;
                  state_n  = GAP;
               end else begin
                  slot_n = slot_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (fall) begin
                  sample  = 1'b1;
                  slot_n  = CNT_W'(1);
                  state_n = CAPT;
               end else if (gap_cnt == GAP_W'(GAP_MAX_P)) begin
                  err     = 1'b1;
                  gap_n   = '0;
                  state_n = IDLE;
               end else begin
                  gap_n = gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               slot_n  = '0;
               gap_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_ext) begin
      if (rst) begin
         state    <= IDLE;
         slot_cnt <= '0;
         gap_cnt  <= '0;
         sync_err <= 1'b0;
      end else begin
         state    <= state_n;
         slot_cnt <= slot_n;
         gap_cnt  <= gap_n;
         sync_err <= err;
      end
   end

   always_ff @(posedge clk_ext) begin
      if (sample) begin
         asm_q <= shift_n;
      end
   end

   // 1-entry output register; a completion while held and not accepted is dropped
   always_ff @(posedge clk_ext) begin
      if (rst) begin
         seq         <= '0;
         frame_valid <= 1'b0;
         frame_data  <= '0;
         frame_seq   <= '0;
         overflow    <= 1'b0;
      end else begin
         if (ovf_clr) begin
            overflow <= 1'b0;
         end
         if (complete) begin
            seq <= seq + SEQ_W_P'(1);
            if (!frame_valid || frame_ready) begin
               frame_valid <= 1'b1;
               frame_data  <= shift_n;
               frame_seq   <= seq;
            end else begin
               overflow <= 1'b1;
            end
         end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ro_frame_capture.sv
// Directed bench for ro_frame_capture: table of whole frames plus hand sequences.
module tb_ro_frame_capture;

   logic        clk_ext;
   logic        rst;
   logic        clk_8;
   logic [1:0]  bus_in;
   logic        cap_en;
   logic        frame_ready;
   logic        ovf_clr;
   logic        frame_valid;
   logic [15:0] frame_data;
   logic [7:0]  frame_seq;
   logic        overflow;
   logic        sync_err;

   int total = 0;
   int bad   = 0;
   int sync_seen = 0;
   int vld_seen  = 0;

   ro_frame_capture dut (
      .clk_ext     (clk_ext),
      .rst         (rst),
      .clk_8       (clk_8),
      .bus_in      (bus_in),
      .cap_en      (cap_en),
      .frame_ready (frame_ready),
      .ovf_clr     (ovf_clr),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_seq   (frame_seq),
      .overflow    (overflow),
      .sync_err    (sync_err)
   );

   initial clk_ext = 1'b0;
   always #5 clk_ext = ~clk_ext;

   typedef struct {
      logic [15:0] pat;
      logic [7:0]  rdy;
      logic [7:0]  clr;
      logic [15:0] d;
      logic [7:0]  s;
      logic        o;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clk_ext cycle: drive at negedge, let the posedge happen, sample at next negedge
   task automatic tick(input logic c8, input logic [1:0] b, input logic rdy, input logic clr);
      logic        pre_v;
      logic [15:0] pre_d;
      logic [7:0]  pre_s;
      pre_v = frame_valid;
      pre_d = frame_data;
      pre_s = frame_seq;
      clk_8       = c8;
      bus_in      = b;
      frame_ready = rdy;
      ovf_clr     = clr;
      @(posedge clk_ext);
      @(negedge clk_ext);
      if (sync_err === 1'b1) sync_seen++;
      if (frame_valid === 1'b1) vld_seen++;
      if (pre_v === 1'b1 && !rdy && !rst) begin
         chk("hold_valid", {31'd0, frame_valid}, 32'd1);
         chk("hold_data", {16'd0, frame_data}, {16'd0, pre_d});
         chk("hold_seq", {24'd0, frame_seq}, {24'd0, pre_s});
      end
   endtask

   // clk_8 low for phases 0..3, high for 4..7; slot k carries pat[2k+1:2k]
   task automatic run_frame(input logic [15:0] pat, input logic [7:0] rdy, input logic [7:0] clr);
      for (int ph = 0; ph < 8; ph++) begin
         tick((ph < 4) ? 1'b0 : 1'b1, pat[2*ph +: 2], rdy[ph], clr[ph]);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] d, input logic [7:0] s, input logic o);
      chk({tag, "_valid"}, {31'd0, frame_valid}, 32'd1);
      chk({tag, "_data"}, {16'd0, frame_data}, {16'd0, d});
      chk({tag, "_seq"}, {24'd0, frame_seq}, {24'd0, s});
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, o});
   endtask

   initial begin
      tbl[0] = '{16'hE4E4, 8'hFF, 8'h00, 16'hE4E4, 8'd0, 1'b0};
      tbl[1] = '{16'hE4E4, 8'hFF, 8'h00, 16'hE4E4, 8'd1, 1'b0};
      tbl[2] = '{16'h1B1B, 8'hFF, 8'h00, 16'h1B1B, 8'd2, 1'b0};
      tbl[3] = '{16'hA5F0, 8'h00, 8'h00, 16'h1B1B, 8'd2, 1'b1};
      tbl[4] = '{16'h3C3C, 8'h00, 8'h00, 16'h1B1B, 8'd2, 1'b1};
      tbl[5] = '{16'h0FF0, 8'hFF, 8'h00, 16'h0FF0, 8'd5, 1'b1};
      tbl[6] = '{16'h9696, 8'hFF, 8'hFF, 16'h9696, 8'd6, 1'b0};
      tbl[7] = '{16'h5A5A, 8'h80, 8'h00, 16'h5A5A, 8'd7, 1'b0};

      rst = 1'b1; cap_en = 1'b1; clk_8 = 1'b1; bus_in = 2'b00;
      frame_ready = 1'b1; ovf_clr = 1'b0;
      @(negedge clk_ext);
      tick(1'b1, 2'b00, 1'b1, 1'b0);
      tick(1'b1, 2'b00, 1'b1, 1'b0);
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_data", {16'd0, frame_data}, 32'd0);
      chk("rst_seq", {24'd0, frame_seq}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_sync", {31'd0, sync_err}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         sync_seen = 0;
         run_frame(tbl[i].pat, tbl[i].rdy, tbl[i].clr);
         chk_out($sformatf("tbl%0d", i), tbl[i].d, tbl[i].s, tbl[i].o);
         chk($sformatf("tbl%0d_sync", i), sync_seen, 32'd0);
      end

      // short frame: extra clk_8 fall after slot 4
      sync_seen = 0; vld_seen = 0;
      tick(1'b0, 2'b11, 1'b1, 1'b0);
      tick(1'b0, 2'b11, 1'b1, 1'b0);
      tick(1'b0, 2'b11, 1'b1, 1'b0);
      tick(1'b0, 2'b11, 1'b1, 1'b0);
      tick(1'b1, 2'b11, 1'b1, 1'b0);
      chk("short_nopartial", {31'd0, frame_valid}, 32'd0);
      run_frame(16'hC3C3, 8'hFF, 8'h00);
      chk("short_sync_cnt", sync_seen, 32'd1);
      chk("short_vld_cnt", vld_seen, 32'd1);
      chk_out("short", 16'hC3C3, 8'd8, 1'b0);

      // clk_8 stops high after a full frame
      sync_seen = 0;
      for (int i = 0; i < 4; i++) tick(1'b1, 2'b00, 1'b1, 1'b0);
      chk("gap_early", sync_seen, 32'd0);
      tick(1'b1, 2'b00, 1'b1, 1'b0);
      chk("gap_pulse", {31'd0, sync_err}, 32'd1);
      tick(1'b1, 2'b00, 1'b1, 1'b0);
      chk("gap_pulse_end", {31'd0, sync_err}, 32'd0);
      for (int i = 0; i < 3; i++) tick(1'b1, 2'b00, 1'b1, 1'b0);
      chk("gap_idle_quiet", sync_seen, 32'd1);
      run_frame(16'hE4E4, 8'hFF, 8'h00);
      chk_out("gap_restart", 16'hE4E4, 8'd9, 1'b0);

      // reset at slot 3 with a held frame and overflow set
      run_frame(16'h1B1B, 8'h00, 8'h00);
      chk_out("pre_rst", 16'hE4E4, 8'd9, 1'b1);
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      tick(1'b0, 2'd1, 1'b0, 1'b0);
      tick(1'b0, 2'd2, 1'b0, 1'b0);
      rst = 1'b1;
      tick(1'b0, 2'd3, 1'b0, 1'b0);
      rst = 1'b0;
      chk("mid_rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("mid_rst_data", {16'd0, frame_data}, 32'd0);
      chk("mid_rst_seq", {24'd0, frame_seq}, 32'd0);
      chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      chk("mid_rst_sync", {31'd0, sync_err}, 32'd0);
      tick(1'b1, 2'd0, 1'b1, 1'b0);
      run_frame(16'hE4E4, 8'hFF, 8'h00);
      chk_out("post_rst", 16'hE4E4, 8'd0, 1'b0);

      // cap_en low for one cycle mid-frame
      sync_seen = 0; vld_seen = 0;
      for (int ph = 0; ph < 4; ph++) tick(1'b0, 2'(ph), 1'b1, 1'b0);
      cap_en = 1'b0;
      tick(1'b1, 2'd0, 1'b1, 1'b0);
      cap_en = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b1, 2'd1, 1'b1, 1'b0);
      chk("capen_sync", sync_seen, 32'd0);
      chk("capen_noframe", vld_seen, 32'd0);
      run_frame(16'h1B1B, 8'hFF, 8'h00);
      chk_out("capen_next", 16'h1B1B, 8'd1, 1'b0);

      // short-frame fall coinciding with cap_en low
      sync_seen = 0; vld_seen = 0;
      for (int ph = 0; ph < 4; ph++) tick(1'b0, 2'(ph), 1'b1, 1'b0);
      tick(1'b1, 2'd0, 1'b1, 1'b0);
      cap_en = 1'b0;
      tick(1'b0, 2'd0, 1'b1, 1'b0);
      cap_en = 1'b1;
      for (int i = 0; i < 3; i++) tick(1'b0, 2'd2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 2'd2, 1'b1, 1'b0);
      chk("fall_capen_sync", sync_seen, 32'd0);
      chk("fall_capen_noframe", vld_seen, 32'd0);
      run_frame(16'hC3C3, 8'hFF, 8'h00);
      chk_out("fall_capen_next", 16'hC3C3, 8'd2, 1'b0);

      // ovf_clr in the same cycle as a drop: set wins
      run_frame(16'h0F0F, 8'h00, 8'h00);
      chk_out("drop1", 16'hC3C3, 8'd2, 1'b1);
      run_frame(16'hF0F0, 8'h00, 8'h80);
      chk_out("drop_clr", 16'hC3C3, 8'd2, 1'b1);
      tick(1'b1, 2'd0, 1'b0, 1'b1);
      chk_out("clr_only", 16'hC3C3, 8'd2, 1'b0);
      run_frame(16'hE4E4, 8'hFF, 8'h00);
      chk_out("after_drops", 16'hE4E4, 8'd5, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
